// File: rtl/dmem_access_unit_if.sv
// Request/response and word-memory bus of the data-memory access unit.
// The unit itself uses the master view; the CPU/memory environment uses slave.
interface dmem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;

  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_error;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_MemRead;
  logic                  mem_MemWrite;
  logic [31:0]           mem_WriteData;
  logic [31:0]           mem_ReadData;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_error,
    output mem_address, mem_MemRead, mem_MemWrite, mem_WriteData,
    input  mem_ReadData
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_MemRead, mem_MemWrite, mem_WriteData,
    output mem_ReadData
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Byte/half/word load-store unit in front of a word-only data memory.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module dmem_access_unit #(
  parameter int MEM_WORDS  = 128,
  parameter int ADDR_WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  dmem_access_unit_if.master bus
);

  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS * 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic                  accept;
  logic                  req_err;

  logic                  error_p0;
  logic                  write_p0;
  logic                  unsigned_p0;
  logic [1:0]            size_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [31:0]           wdata_p0;
  logic [31:0]           word_p1;

  // Lane extraction and sign/zero extension of a loaded word.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'd0:    ext = uns ? $signed({24'h0, b}) : b;
      2'd1:    ext = uns ? $signed({16'h0, h}) : h;
      default: ext = $signed(word);
    endcase
    return ext;
  endfunction

  // Replace the addressed lane of the old word with the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] merged;
    merged = word;
    case (size)
      2'd0:    merged[{lane, 3'b000} +: 8]    = data[7:0];
      2'd1:    merged[{lane[1], 4'b0000} +: 16] = data[15:0];
      default: merged = data;
    endcase
    return merged;
  endfunction

  assign accept = (state == IDLE) && bus.req_valid;

  always_comb begin
    req_err = (bus.req_size == 2'd3) || ({1'b0, bus.req_addr} >= ADDR_LIMIT);
`ifdef MISALIGN_TRAP_EN
    if ((bus.req_size == 2'd1) && bus.req_addr[0])
      req_err = 1'b1;
    if ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`endif
  end

  // p0: request captured at acceptance
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      error_p0 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        error_p0 <= req_err;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      write_p0    <= bus.req_write;
      unsigned_p0 <= bus.req_unsigned;
      size_p0     <= bus.req_size;
      addr_p0     <= bus.req_addr;
      wdata_p0    <= bus.req_wdata;
    end
  end

  // p1: memory word captured at the end of the RD cycle
  always_ff @(posedge clock) begin
    if (state == RD)
      word_p1 <= bus.mem_ReadData;
  end

  always_comb begin
    state_nxt         = state;
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_error    = 1'b0;
    bus.resp_rdata    = 32'h0;
    bus.mem_address   = '0;
    bus.mem_MemRead   = 1'b0;
    bus.mem_MemWrite  = 1'b0;
    bus.mem_WriteData = 32'h0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err)
            state_nxt = RESP;
          else if (bus.req_write && (bus.req_size == 2'd2))
            state_nxt = WR;
          else
            state_nxt = RD;
        end
      end
      RD: begin
        bus.mem_MemRead = 1'b1;
        bus.mem_address = {addr_p0[ADDR_WIDTH-1:2], 2'b00};
        state_nxt       = write_p0 ? WR : RESP;
      end
      WR: begin
        // Word stores ignore word_p1; sub-word stores merge into it.
        bus.mem_MemWrite  = 1'b1;
        bus.mem_address   = {addr_p0[ADDR_WIDTH-1:2], 2'b00};
        bus.mem_WriteData = store_merge(word_p1, wdata_p0, size_p0, addr_p0[1:0]);
        state_nxt         = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_error = error_p0;
        if (!error_p0 && !write_p0)
          bus.resp_rdata = load_extend(word_p1, size_p0, addr_p0[1:0], unsigned_p0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Initiator-side load/store unit between the CPU datapath and the word-only data memory.
- The data memory has a 32-bit word port with combinational read, and writes on the clock edge only when write is high and read is low.
- This block converts byte, halfword and word load/store requests into that protocol:
  - read-modify-write for sub-word stores;
  - lane extraction and sign/zero extension for sub-word loads.
- Single outstanding request, valid/ready request side, one-cycle response pulse.

Parameters:
- MEM_WORDS, 128, number of 32-bit words in the data memory; byte addresses >= MEM_WORDS*4 are out of range.
- ADDR_WIDTH, 32, width of request and memory addresses.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data; the low bits are used for sub-word stores.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  qualified by resp_valid; request was rejected.
- mem_address  out  ADDR_WIDTH  word-aligned address to memory; bits [1:0] always 0.
- mem_MemRead  out  1  memory read strobe.
- mem_MemWrite  out  1  memory write strobe.
- mem_WriteData  out  32  memory write data.
- mem_ReadData  in  32  combinational memory read data.

Behaviour:
- Reset values:
  - state IDLE, req_ready = 1;
  - resp_valid, resp_error, mem_MemRead, mem_MemWrite = 0;
  - resp_rdata, mem_address, mem_WriteData = 0.
- Reset asserted mid-operation: FSM returns to IDLE at the next edge and any pending write is abandoned. mem_MemWrite is registered, so a write is either fully issued or not issued.
- Acceptance: a request is accepted on an edge where req_valid && req_ready. All req_* fields are registered at that edge; later input changes are ignored.
- Error check is done at acceptance. A request is an error when:
  - req_size = 3, or
  - addr >= MEM_WORDS*4, or
  - it is misaligned and MISALIGN_TRAP_EN is defined.
- Error path: IDLE -> RESP with resp_error = 1, resp_rdata = 0. No memory strobe is asserted.
- States: IDLE, RD, WR, RESP.
  - Load: IDLE -> RD -> RESP.
  - Word store: IDLE -> WR -> RESP.
  - Sub-word store: IDLE -> RD -> WR -> RESP.
  - RESP -> IDLE unconditionally.
  - req_ready = 1 only in IDLE.
- RD state:
  - mem_MemRead = 1, mem_MemWrite = 0, mem_address = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - mem_ReadData is captured at the end of the cycle.
- WR state:
  - mem_MemWrite = 1 and mem_MemRead = 0; both must never be high together.
  - mem_WriteData: the word for word stores; the captured word with the addressed lane replaced for sub-word stores.
  - Byte lane = addr[1:0]; bytes are little-endian, byte 0 = bits [7:0].
  - Half lane = addr[1]; half 0 = bits [15:0].
- RESP state: resp_valid = 1 for exactly one cycle.
  - Load: byte = lane value extended from bit 7; half = lane value extended from bit 15; word = raw word.
  - Store: resp_rdata = 0.
- Latency from the accepting edge to resp_valid: load 2 cycles, word store 2 cycles, sub-word store 3 cycles, error 1 cycle.
- Back-to-back operation: a new request can be accepted in the cycle after RESP. Minimum issue interval is 3 cycles for loads.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, is an error. It takes the error path with no memory access.
- Undefined: offending low address bits are ignored. A half access uses lane addr[1]; a word access uses the aligned word. resp_error is raised only for an illegal size or an out-of-range address.

Test Plan:
- Word store 0xDEADBEEF to 0x10, then word load from 0x10:
  - store: exactly one mem_MemWrite cycle with mem_address = 0x10, resp_valid 2 cycles after acceptance;
  - load: resp_rdata = 0xDEADBEEF, resp_error = 0.
- With mem word 0x10 = 0x11223344, byte store 0xAA to 0x12:
  - RD cycle, then WR with mem_WriteData = 0x11AA3344;
  - mem_MemRead and mem_MemWrite are never high together;
  - resp_valid 3 cycles after acceptance.
- With word 0x80FF7F01 at 0x20, loads return:
  - signed byte at 0x22 -> 0xFFFFFFFF;
  - unsigned byte at 0x22 -> 0x000000FF;
  - signed half at 0x20 -> 0x00007F01;
  - signed half at 0x22 -> 0xFFFF80FF.
- Load from 0x200 (MEM_WORDS = 128), and any request with req_size = 3:
  - resp_valid one cycle after acceptance with resp_error = 1, resp_rdata = 0;
  - no memory strobe.
- Word load from 0x22:
  - MISALIGN_TRAP_EN defined: resp_error = 1.
  - MISALIGN_TRAP_EN undefined: returns the word at 0x20.
- Reset low during the RD cycle of a sub-word store:
  - next cycle is IDLE with all outputs at reset values;
  - mem_MemWrite is never asserted and the memory is unchanged.
